// File: rtl/sipo_nbit_rx_if.sv
// Serial-in / parallel-out bus between a bit-stream source and sipo_nbit_rx.
// The master drives the strobed serial bit; the slave returns the reassembled word.
interface sipo_nbit_rx_if #(
    parameter int unsigned N = 4
);
    logic         en_in;
    logic         start_in;
    logic         d_in;
    logic [N-1:0] q_out;
    logic         valid_out;
    logic         busy_out;
    logic         err_out;

    modport master (
        output en_in, start_in, d_in,
        input  q_out, valid_out, busy_out, err_out
    );

    modport slave (
        input  en_in, start_in, d_in,
        output q_out, valid_out, busy_out, err_out
    );
endinterface

// File: rtl/sipo_nbit_rx.sv
// Reassembles N-bit words from a start-framed serial stream (one bit per enabled clock).
// Completed words are registered on q_out with a one-cycle valid pulse; cut-short words pulse err_out.
module sipo_nbit_rx #(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_ah_in,
    sipo_nbit_rx_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [N-1:0]     sr;
    logic [CNT_W-1:0] cnt;

    // Shift one bit in from the side that leaves the first bit at its final position after N inserts.
    function automatic logic [N-1:0] insert(input logic [N-1:0] s, input logic b);
        if (MSB_FIRST) begin
            insert = {s[N-2:0], b};
        end else begin
            insert = {b, s[N-1:1]};
        end
    endfunction

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state         <= IDLE;
            sr            <= '0;
            cnt           <= '0;
            bus.q_out     <= '0;
            bus.valid_out <= 1'b0;
            bus.busy_out  <= 1'b0;
            bus.err_out   <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.err_out   <= 1'b0;
            case (state)
                IDLE: begin
                    // Stray bits without a start strobe are dropped silently.
                    if (bus.en_in && bus.start_in) begin
                        sr           <= insert('0, bus.d_in);
                        cnt          <= CNT_W'(1);
                        state        <= SHIFT;
                        bus.busy_out <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.en_in) begin
                        if (bus.start_in) begin
                            // Restart framing: discard partial word, current bit opens the new one.
                            sr          <= insert('0, bus.d_in);
                            cnt         <= CNT_W'(1);
                            bus.err_out <= 1'b1;
                        end else if (cnt == CNT_W'(N - 1)) begin
                            bus.q_out     <= insert(sr, bus.d_in);
                            bus.valid_out <= 1'b1;
                            cnt           <= '0;
                            state         <= IDLE;
                            bus.busy_out  <= 1'b0;
                        end else begin
                            sr  <= insert(sr, bus.d_in);
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    bus.busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule
